// File: rtl/valu_pipe_if.sv
// Issue/writeback bundle of the pipelined SIMD vector ALU.
// The master drives issues and the writeback grant; the slave is the ALU.
interface valu_pipe_if #(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3
);
    logic                     flush_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [3:0]               op_i;
    logic [1:0]               ew_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [XLEN-1:0]          result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;
    logic                     illegal_o;

    modport master (
        output flush_i, valid_i, op_i, ew_i, operand_a_i, operand_b_i, trans_id_i, ready_i,
        input  ready_o, valid_o, result_o, trans_id_o, illegal_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, ew_i, operand_a_i, operand_b_i, trans_id_i, ready_i,
        output ready_o, valid_o, result_o, trans_id_o, illegal_o
    );
endinterface

// File: rtl/valu_pipe.sv
// Pipelined SIMD vector ALU: lane-split compute ahead of stage 1, then a
// valid/data/ID delay chain of NR_STAGES registers with a global stall.
module valu_pipe #(
    parameter int XLEN          = 64,
    parameter int NR_STAGES     = 2,
    parameter int TRANS_ID_BITS = 3,
    parameter bit SAT_EN        = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    valu_pipe_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDS = 4'd2;
    localparam logic [3:0] OP_SUBS = 4'd3;
    localparam logic [3:0] OP_MIN  = 4'd4;
    localparam logic [3:0] OP_MAX  = 4'd5;
    localparam logic [3:0] OP_MINU = 4'd6;
    localparam logic [3:0] OP_MAXU = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_SLL  = 4'd11;
    localparam logic [3:0] OP_SRL  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;

    // Clamp a sign-extended lane sum to the signed range of a w-bit lane.
    function automatic logic [63:0] sat_clamp(input logic signed [64:0] v, input int w);
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (v > hi)
            return hi[63:0];
        else if (v < lo)
            return lo[63:0];
        else
            return v[63:0];
    endfunction

    logic [3:0][XLEN-1:0] w_lanes;
    logic [XLEN-1:0]      w_res;
    logic                 w_ill;
    logic                 w_adv;
    logic                 w_acc;

    for (genvar e = 0; e < 4; e++) begin : g_ew
        localparam int W   = 8 << e;
        localparam int SHW = $clog2(W);
        if (W <= XLEN) begin : g_on
            for (genvar l = 0; l < XLEN / W; l++) begin : g_lane
                logic signed [W-1:0] w_a;
                logic signed [W-1:0] w_b;
                logic [SHW-1:0]      w_sh;
                logic signed [W:0]   w_sum;
                logic signed [W:0]   w_dif;
                logic [63:0]         w_adds_x;
                logic [63:0]         w_subs_x;
                logic [W-1:0]        w_lane;

                assign w_a      = bus.operand_a_i[l*W +: W];
                assign w_b      = bus.operand_b_i[l*W +: W];
                assign w_sh     = w_b[SHW-1:0];
                assign w_sum    = {w_a[W-1], w_a} + {w_b[W-1], w_b};
                assign w_dif    = {w_a[W-1], w_a} - {w_b[W-1], w_b};
                assign w_adds_x = sat_clamp(65'(w_sum), W);
                assign w_subs_x = sat_clamp(65'(w_dif), W);

                always_comb begin
                    w_lane = '0;
                    case (bus.op_i)
                        OP_ADD:  w_lane = w_a + w_b;
                        OP_SUB:  w_lane = w_a - w_b;
                        OP_ADDS: w_lane = w_adds_x[W-1:0];
                        OP_SUBS: w_lane = w_subs_x[W-1:0];
                        OP_MIN:  w_lane = (w_a < w_b) ? w_a : w_b;
                        OP_MAX:  w_lane = (w_a > w_b) ? w_a : w_b;
                        OP_MINU: w_lane = ($unsigned(w_a) < $unsigned(w_b)) ? w_a : w_b;
                        OP_MAXU: w_lane = ($unsigned(w_a) > $unsigned(w_b)) ? w_a : w_b;
                        OP_AND:  w_lane = w_a & w_b;
                        OP_OR:   w_lane = w_a | w_b;
                        OP_XOR:  w_lane = w_a ^ w_b;
                        OP_SLL:  w_lane = $unsigned(w_a << w_sh);
                        OP_SRL:  w_lane = $unsigned(w_a) >> w_sh;
                        OP_SRA:  w_lane = $unsigned(w_a >>> w_sh);
                        default: w_lane = '0;
                    endcase
                end

                assign w_lanes[e][l*W +: W] = w_lane;
            end
        end else begin : g_off
            assign w_lanes[e] = '0;
        end
    end

    assign w_ill = (bus.op_i >= 4'd14)
                 | ((bus.ew_i == 2'd3) && (XLEN == 32))
                 | (!SAT_EN && ((bus.op_i == OP_ADDS) || (bus.op_i == OP_SUBS)));
    assign w_res = w_ill ? '0 : w_lanes[bus.ew_i];

    // Whole pipe advances together; no bubble collapsing.
    assign w_adv       = !bus.valid_o | bus.ready_i;
    assign w_acc       = bus.valid_i & w_adv & !bus.flush_i;
    assign bus.ready_o = w_adv;

    logic [NR_STAGES-1:0]     r_vld_p;
    logic [XLEN-1:0]          r_res_p [NR_STAGES];
    logic [TRANS_ID_BITS-1:0] r_id_p  [NR_STAGES];
    logic                     r_ill_p [NR_STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_vld_p <= '0;
        end else if (w_adv) begin
            r_vld_p[0] <= w_acc;
            for (int k = 1; k < NR_STAGES; k++)
                r_vld_p[k] <= r_vld_p[k-1];
        end
    end

    // Stage 1 data only toggles on an accepted issue; later stages on a live slot.
    always_ff @(posedge clk_i) begin
        if (w_acc) begin
            r_res_p[0] <= w_res;
            r_id_p[0]  <= bus.trans_id_i;
            r_ill_p[0] <= w_ill;
        end
        for (int k = 1; k < NR_STAGES; k++) begin
            if (w_adv && r_vld_p[k-1]) begin
                r_res_p[k] <= r_res_p[k-1];
                r_id_p[k]  <= r_id_p[k-1];
                r_ill_p[k] <= r_ill_p[k-1];
            end
        end
    end

    assign bus.valid_o    = r_vld_p[NR_STAGES-1];
    assign bus.result_o   = bus.valid_o ? r_res_p[NR_STAGES-1] : '0;
    assign bus.trans_id_o = bus.valid_o ? r_id_p[NR_STAGES-1] : '0;
    assign bus.illegal_o  = bus.valid_o & r_ill_p[NR_STAGES-1];
endmodule

// File: tb/tb_valu_pipe.sv
// Bench for valu_pipe: directed scenarios plus randomized traffic checked
// every cycle against a lane-arithmetic model with an in-order result queue.
module tb_valu_pipe;
    localparam int XLEN = 64;
    localparam int NRS  = 2;
    localparam int TIDB = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    valu_pipe_if #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB)) bus ();

    valu_pipe #(
        .XLEN(XLEN), .NR_STAGES(NRS), .TRANS_ID_BITS(TIDB), .SAT_EN(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0]     res;
        logic [TIDB-1:0] id;
        logic            ill;
        int              due;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: each lane treated as an independent integer of width 8<<ew.
    function automatic logic [64:0] ref_alu(input logic [3:0] op, input logic [1:0] ew,
                                            input logic [63:0] a, input logic [63:0] b);
        int                 w;
        int                 sh;
        logic [63:0]        mask, ua, ub, r, res;
        logic signed [65:0] sa, sb, s, lim_hi, lim_lo;
        w = 8 << ew;
        if (op >= 4'd14) return {1'b1, 64'd0};
        mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        lim_hi = (66'sd1 <<< (w - 1)) - 66'sd1;
        lim_lo = -(66'sd1 <<< (w - 1));
        res    = '0;
        for (int l = 0; l < 64 / w; l++) begin
            ua = (a >> (l * w)) & mask;
            ub = (b >> (l * w)) & mask;
            sa = $signed({2'b00, ua});
            if (ua[w-1]) sa = sa - (66'sd1 <<< w);
            sb = $signed({2'b00, ub});
            if (ub[w-1]) sb = sb - (66'sd1 <<< w);
            sh = int'(ub % 64'(w));
            case (op)
                4'd0:  r = ua + ub;
                4'd1:  r = ua - ub;
                4'd2:  begin s = sa + sb; s = (s > lim_hi) ? lim_hi : (s < lim_lo) ? lim_lo : s; r = s[63:0]; end
                4'd3:  begin s = sa - sb; s = (s > lim_hi) ? lim_hi : (s < lim_lo) ? lim_lo : s; r = s[63:0]; end
                4'd4:  r = (sa < sb) ? ua : ub;
                4'd5:  r = (sa > sb) ? ua : ub;
                4'd6:  r = (ua < ub) ? ua : ub;
                4'd7:  r = (ua > ub) ? ua : ub;
                4'd8:  r = ua & ub;
                4'd9:  r = ua | ub;
                4'd10: r = ua ^ ub;
                4'd11: r = ua << sh;
                4'd12: r = ua >> sh;
                4'd13: begin s = sa >>> sh; r = s[63:0]; end
                default: r = '0;
            endcase
            res = res | ((r & mask) << (l * w));
        end
        return {1'b0, res};
    endfunction

    always @(negedge clk_i) begin : mon
        logic        ev;
        logic [64:0] m;
        exp_t        e;
        if (mon_en) begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("valid_o", 65'(bus.valid_o), 65'(ev));
            chk("ready_o", 65'(bus.ready_o), 65'(!ev || bus.ready_i));
            if (ev) begin
                chk("result_o", 65'(bus.result_o), 65'(q[0].res));
                chk("trans_id_o", 65'(bus.trans_id_o), 65'(q[0].id));
                chk("illegal_o", 65'(bus.illegal_o), 65'(q[0].ill));
            end
            if (ev && bus.ready_i)
                void'(q.pop_front());
            else if (ev)
                foreach (q[i]) q[i].due++;
            if (rst_i || bus.flush_i) begin
                q.delete();
            end else if (bus.valid_i && (!ev || bus.ready_i)) begin
                m     = ref_alu(bus.op_i, bus.ew_i, bus.operand_a_i, bus.operand_b_i);
                e.res = m[63:0];
                e.ill = m[64];
                e.id  = bus.trans_id_i;
                e.due = cyc + NRS;
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] ew, input logic [63:0] a,
                         input logic [63:0] b, input logic [TIDB-1:0] id);
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.ew_i        = ew;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.trans_id_i  = id;
    endtask

    // Single op into an empty pipe with ready_i=1: visible exactly NRS edges later.
    task automatic run1(input string nm, input logic [3:0] op, input logic [1:0] ew,
                        input logic [63:0] a, input logic [63:0] b, input logic [TIDB-1:0] id,
                        input logic [63:0] er, input logic eill);
        drive(op, ew, a, b, id);
        tick();
        bus.valid_i = 1'b0;
        chk({nm, "_early"}, 65'(bus.valid_o), 65'd0);
        tick();
        chk({nm, "_valid"}, 65'(bus.valid_o), 65'd1);
        chk({nm, "_res"}, 65'(bus.result_o), 65'(er));
        chk({nm, "_id"}, 65'(bus.trans_id_o), 65'(id));
        chk({nm, "_ill"}, 65'(bus.illegal_o), 65'(eill));
    endtask

    function automatic logic [63:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 64'h7F7F_7FFF_7FFF_FFFF;
            1:       return 64'h8080_8000_8000_0000;
            2:       return {64{1'b1}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.op_i = '0; bus.ew_i = '0;
        bus.operand_a_i = '0; bus.operand_b_i = '0; bus.trans_id_i = '0; bus.ready_i = 1'b1;

        chk("pin_add", ref_alu(4'd0, 2'd0, 64'hFF, 64'h1), {1'b0, 64'h0});
        chk("pin_adds", ref_alu(4'd2, 2'd1, 64'h7FFF_8000_0001_7FFF, 64'h0001_FFFF_0001_0000),
            {1'b0, 64'h7FFF_8000_0002_7FFF});
        chk("pin_sra", ref_alu(4'd13, 2'd2, 64'h8000_0000_8000_0000, 64'h0000_0024_0000_0024),
            {1'b0, 64'hF800_0000_F800_0000});
        chk("pin_min", ref_alu(4'd4, 2'd2, {64{1'b1}}, 64'h0000_0001_0000_0001),
            {1'b0, {64{1'b1}}});

        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_valid", 65'(bus.valid_o), 65'd0);
        chk("rst_res", 65'(bus.result_o), 65'd0);
        chk("rst_id", 65'(bus.trans_id_o), 65'd0);
        chk("rst_ill", 65'(bus.illegal_o), 65'd0);
        rst_i = 1'b0;

        run1("add_iso", 4'd0, 2'd0, 64'hFF, 64'h1, 3'd5, 64'h0, 1'b0);
        run1("adds", 4'd2, 2'd1, 64'h7FFF_8000_0001_7FFF, 64'h0001_FFFF_0001_0000, 3'd1,
             64'h7FFF_8000_0002_7FFF, 1'b0);
        run1("subs", 4'd3, 2'd1, 64'h8000, 64'h1, 3'd2, 64'h8000, 1'b0);
        run1("sra", 4'd13, 2'd2, 64'h8000_0000_8000_0000, 64'h0000_0024_0000_0024, 3'd3,
             64'hF800_0000_F800_0000, 1'b0);
        run1("minu", 4'd6, 2'd2, {64{1'b1}}, 64'h0000_0001_0000_0001, 3'd4,
             64'h0000_0001_0000_0001, 1'b0);
        run1("min", 4'd4, 2'd2, {64{1'b1}}, 64'h0000_0001_0000_0001, 3'd6, {64{1'b1}}, 1'b0);
        run1("illegal", 4'd14, 2'd0, 64'h1234, 64'h5678, 3'd7, 64'h0, 1'b1);
        tick();

        // Back-pressure: IDs 1,2,3 back to back, stall while ID1 is at the output.
        drive(4'd0, 2'd0, 64'd10, 64'd1, 3'd1); tick();
        drive(4'd0, 2'd0, 64'd20, 64'd2, 3'd2); tick();
        drive(4'd0, 2'd0, 64'd30, 64'd3, 3'd3);
        bus.ready_i = 1'b0;
        #1;
        chk("bp_ready", 65'(bus.ready_o), 65'd0);
        chk("bp_hold_id", 65'(bus.trans_id_o), 65'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_v", 65'(bus.valid_o), 65'd1);
            chk("bp_hold_id", 65'(bus.trans_id_o), 65'd1);
            chk("bp_hold_res", 65'(bus.result_o), 65'd11);
        end
        bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        chk("bp_id2", 65'(bus.trans_id_o), 65'd2);
        tick();
        chk("bp_id3", 65'(bus.trans_id_o), 65'd3);
        tick();
        chk("bp_drained", 65'(bus.valid_o), 65'd0);

        // Flush: ID4 in flight, ID5 offered with the flush, ID6 right after.
        drive(4'd8, 2'd3, 64'hF0, 64'hFF, 3'd4); tick();
        drive(4'd9, 2'd3, 64'h0F, 64'h10, 3'd5);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("fl_v0", 65'(bus.valid_o), 65'd0);
        drive(4'd10, 2'd3, 64'hFF, 64'h0F, 3'd6);
        tick();
        bus.valid_i = 1'b0;
        chk("fl_v1", 65'(bus.valid_o), 65'd0);
        tick();
        chk("fl_id6_v", 65'(bus.valid_o), 65'd1);
        chk("fl_id6_id", 65'(bus.trans_id_o), 65'd6);
        chk("fl_id6_res", 65'(bus.result_o), 65'hF0);
        tick();
        chk("fl_after", 65'(bus.valid_o), 65'd0);

        // Reset with two operations in flight.
        drive(4'd0, 2'd1, 64'd1, 64'd1, 3'd1); tick();
        drive(4'd1, 2'd1, 64'd5, 64'd1, 3'd2); tick();
        bus.valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mrst_v", 65'(bus.valid_o), 65'd0);
        chk("mrst_res", 65'(bus.result_o), 65'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst_quiet", 65'(bus.valid_o), 65'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            bus.valid_i     = ($urandom_range(0, 99) < 60);
            bus.op_i        = 4'($urandom_range(0, 15));
            bus.ew_i        = 2'($urandom_range(0, 3));
            bus.operand_a_i = rand_opnd();
            bus.operand_b_i = rand_opnd();
            bus.trans_id_i  = TIDB'($urandom_range(0, 7));
            bus.ready_i     = ($urandom_range(0, 99) < 70);
            bus.flush_i     = ($urandom_range(0, 99) < 3);
            rst_i           = ($urandom_range(0, 999) < 5);
            tick();
        end
        bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.ready_i = 1'b1; rst_i = 1'b0;
        repeat (NRS + 4) tick();
        chk("drain_empty", 65'(q.size()), 65'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
